combo_lock_seq: RTL and testbench

COMBO_LOCK_SEQ -- requirements
Module: combo_lock_seq

---
 rtl/combo_lock_seq.sv | 169 ++++++++++++++++
 tb/tb_combo_lock_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_seq.sv
// Serial combination lock with overlap-aware code matching.
// Define COMBO_LOCK_LOCKOUT_EN to enable failure counting and the timed lockout.
module combo_lock_seq #(
    parameter int                  CODE_LEN       = 5,
    parameter logic [CODE_LEN-1:0] CODE           = 5'b01011,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             zero,
    input  logic                             one,
    output logic                             unlocked,
    output logic [$clog2(CODE_LEN+1)-1:0]    state,
    output logic                             locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

    localparam int KW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);

    if (CODE_LEN < 2 || CODE_LEN > 16) begin : g_bad_code_len
        $error("combo_lock_seq: CODE_LEN must be in 2..16");
    end
    if (MAX_FAILS < 1 || MAX_FAILS > 15) begin : g_bad_max_fails
        $error("combo_lock_seq: MAX_FAILS must be in 1..15");
    end
    if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535) begin : g_bad_lockout
        $error("combo_lock_seq: LOCKOUT_CYCLES must be in 1..65535");
    end

`ifdef COMBO_LOCK_LOCKOUT_EN
    typedef enum logic [1:0] {SEARCH, OPEN, LOCKOUT} fsm_t;
`else
    typedef enum logic [0:0] {SEARCH, OPEN} fsm_t;
`endif

    fsm_t                fsm_q, fsm_d;
    logic [KW-1:0]       k_q, k_d;
    // Only the older CODE_LEN-1 bits are stored; the incoming bit completes the window.
    logic [CODE_LEN-2:0] hist_q, hist_d;
    logic                unlocked_q;

    logic                bit_evt;
    logic [CODE_LEN-1:0] window;
    logic [KW-1:0]       limit;
    logic [KW-1:0]       match_k;
    logic [CODE_LEN-1:0] mask;

`ifdef COMBO_LOCK_LOCKOUT_EN
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          locked_q;
`endif

    // Leaving OPEN discards the old history, so the new bit is matched as the first one.
    always_comb begin
        bit_evt = zero ^ one;
        if (fsm_q == OPEN) begin
            window = {{(CODE_LEN-1){1'b0}}, one};
            limit  = '0;
        end else begin
            window = {hist_q, one};
            limit  = k_q;
        end
    end

    // A suffix can only match if it extends the previous match by at most one bit,
    // which also keeps never-written history bits out of the comparison.
    always_comb begin
        match_k = '0;
        mask    = '0;
        for (int j = 1; j <= CODE_LEN; j++) begin
            mask = {CODE_LEN{1'b1}} >> (CODE_LEN - j);
            if (j <= int'(limit) + 1 &&
                ((window & mask) == ((CODE >> (CODE_LEN - j)) & mask))) begin
                match_k = KW'(j);
            end
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        k_d    = k_q;
        hist_d = hist_q;
`ifdef COMBO_LOCK_LOCKOUT_EN
        fail_d  = fail_q;
        timer_d = timer_q;
`endif
        case (fsm_q)
            SEARCH, OPEN: begin
                if (bit_evt) begin
                    fsm_d  = SEARCH;
                    hist_d = window[CODE_LEN-2:0];
                    k_d    = match_k;
                    if (match_k == KW'(CODE_LEN)) begin
                        fsm_d = OPEN;
`ifdef COMBO_LOCK_LOCKOUT_EN
                        fail_d = '0;
                    end else if (k_q != '0 && match_k <= k_q && fsm_q == SEARCH) begin
                        if (fail_q == FW'(MAX_FAILS - 1)) begin
                            fsm_d   = LOCKOUT;
                            k_d     = '0;
                            hist_d  = '0;
                            fail_d  = '0;
                            timer_d = TW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            fail_d = fail_q + FW'(1);
                        end
`endif
                    end
                end
            end
`ifdef COMBO_LOCK_LOCKOUT_EN
            LOCKOUT: begin
                if (timer_q == '0) begin
                    fsm_d = SEARCH;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
`endif
            default: begin
                fsm_d  = SEARCH;
                k_d    = '0;
                hist_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= SEARCH;
            k_q        <= '0;
            hist_q     <= '0;
            unlocked_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            k_q        <= k_d;
            hist_q     <= hist_d;
            unlocked_q <= (fsm_d == OPEN);
        end
    end

`ifdef COMBO_LOCK_LOCKOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_q   <= '0;
            timer_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            locked_q <= (fsm_d == LOCKOUT);
        end
    end

    assign locked_out = locked_q;
    assign fail_count = fail_q;
`else
    assign locked_out = 1'b0;
    assign fail_count = '0;
`endif

    assign unlocked = unlocked_q;
    assign state    = k_q;

endmodule

// File: tb/tb_combo_lock_seq.sv
// Randomised and directed checks of combo_lock_seq against a queue-based lock model.
// Follows COMBO_LOCK_LOCKOUT_EN the same way the design does.
module tb_combo_lock_seq;

    localparam int                  CODE_LEN       = 5;
    localparam logic [CODE_LEN-1:0] CODE           = 5'b01011;
    localparam int                  MAX_FAILS      = 3;
    localparam int                  LOCKOUT_CYCLES = 16;
    localparam int                  KW             = $clog2(CODE_LEN + 1);
    localparam int                  FW             = $clog2(MAX_FAILS + 1);
`ifdef COMBO_LOCK_LOCKOUT_EN
    localparam int                  LOCK_EN        = 1;
`else
    localparam int                  LOCK_EN        = 0;
`endif

    logic          clk  = 1'b0;
    logic          rst  = 1'b0;
    logic          zero = 1'b0;
    logic          one  = 1'b0;
    logic          unlocked;
    logic [KW-1:0] state;
    logic          locked_out;
    logic [FW-1:0] fail_count;

    int n_checks = 0;
    int n_miss   = 0;
    bit check_en = 1'b0;

    logic [CODE_LEN-1:0] code_v = CODE;

    bit m_open        = 1'b0;
    bit m_lock        = 1'b0;
    int m_k           = 0;
    int m_fails       = 0;
    int m_lock_cycles = 0;
    bit m_hist[$];

    combo_lock_seq #(
        .CODE_LEN(CODE_LEN),
        .CODE(CODE),
        .MAX_FAILS(MAX_FAILS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .zero(zero),
        .one(one),
        .unlocked(unlocked),
        .state(state),
        .locked_out(locked_out),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // Longest suffix of the bits entered since the last clear that equals a prefix of the code.
    function automatic int longest_match();
        int n = m_hist.size();
        for (int len = (n < CODE_LEN) ? n : CODE_LEN; len >= 1; len--) begin
            bit ok = 1'b1;
            for (int i = 0; i < len; i++) begin
                if (m_hist[n - len + i] != code_v[CODE_LEN - 1 - i]) ok = 1'b0;
            end
            if (ok) return len;
        end
        return 0;
    endfunction

    task automatic model_step(input bit z, input bit o, input bit r);
        int old_k;
        int new_k;
        if (r) begin
            m_open = 1'b0; m_lock = 1'b0; m_k = 0; m_fails = 0; m_lock_cycles = 0;
            m_hist.delete();
        end else if (m_lock) begin
            m_lock_cycles++;
            if (m_lock_cycles == LOCKOUT_CYCLES) m_lock = 1'b0;
        end else if (z != o) begin
            if (m_open) begin
                m_open = 1'b0;
                m_k    = 0;
                m_hist.delete();
            end
            old_k = m_k;
            m_hist.push_back(o);
            if (m_hist.size() > CODE_LEN) void'(m_hist.pop_front());
            new_k = longest_match();
            m_k   = new_k;
            if (new_k == CODE_LEN) begin
                m_open  = 1'b1;
                m_fails = 0;
            end else if (LOCK_EN != 0 && old_k > 0 && new_k <= old_k) begin
                m_fails++;
                if (m_fails == MAX_FAILS) begin
                    m_lock = 1'b1; m_lock_cycles = 0; m_fails = 0; m_k = 0;
                    m_hist.delete();
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit z, input bit o, input bit r);
        zero = z;
        one  = o;
        rst  = r;
        @(posedge clk);
        model_step(z, o, r);
        #1;
    endtask

    task automatic applyBit(input bit b);
        applyStimulus(!b, b, 1'b0);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_unlocked",   int'(unlocked),   int'(m_open));
            checkOutput("model_state",      int'(state),      m_k);
            checkOutput("model_locked_out", int'(locked_out), int'(m_lock));
            checkOutput("model_fail_count", int'(fail_count), m_fails);
        end
    end

    initial begin
        bit seq_a[5] = '{0, 1, 0, 1, 1};
        bit seq_b[7] = '{0, 1, 0, 1, 0, 1, 1};

        applyStimulus(0, 0, 1);
        check_en = 1'b1;
        applyStimulus(0, 0, 1);
        checkOutput("rst_state",      state,      0);
        checkOutput("rst_unlocked",   unlocked,   0);
        checkOutput("rst_locked_out", locked_out, 0);
        checkOutput("rst_fail_count", fail_count, 0);

        // Straight entry of the code
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyBit(seq_a[i]);
            checkOutput("straight_state", state, i + 1);
        end
        checkOutput("straight_unlocked", unlocked, 1);
        checkOutput("straight_fail",     fail_count, 0);
        applyBit(1'b0);
        checkOutput("reopen_unlocked", unlocked, 0);
        checkOutput("reopen_state",    state,    1);

        // Overlapping entry with one failure on the way
        applyStimulus(0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            applyBit(seq_b[i]);
            if (i == 4) begin
                checkOutput("overlap_state5", state,      3);
                checkOutput("overlap_fail5",  fail_count, LOCK_EN);
            end
        end
        checkOutput("overlap_unlocked", unlocked,   1);
        checkOutput("overlap_fail7",    fail_count, 0);

        // Both strobes high is not an event
        applyStimulus(0, 0, 1);
        applyBit(1'b0);
        applyBit(1'b0);
        applyBit(1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0);
        checkOutput("both_state", state,      2);
        checkOutput("both_fail",  fail_count, LOCK_EN);

`ifdef COMBO_LOCK_LOCKOUT_EN
        applyStimulus(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            applyBit(1'b0);
            if (i == 1) checkOutput("lock_fail2", fail_count, 1);
            if (i == 2) checkOutput("lock_fail3", fail_count, 2);
        end
        checkOutput("lock_entered", locked_out, 1);
        checkOutput("lock_state",   state,      0);
        checkOutput("lock_fail0",   fail_count, 0);
        for (int i = 0; i < 5; i++) applyBit(seq_a[i]);
        checkOutput("lock_ignored", unlocked, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0);
        checkOutput("lock_last_cycle", locked_out, 1);
        applyStimulus(0, 0, 0);
        checkOutput("lock_released", locked_out, 0);
        checkOutput("lock_rel_state", state,     0);

        applyStimulus(0, 0, 1);
        for (int i = 0; i < 4; i++) applyBit(1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0);
        checkOutput("lockrst_before", locked_out, 1);
        applyStimulus(1, 0, 1);
        checkOutput("lockrst_locked", locked_out, 0);
        checkOutput("lockrst_state",  state,      0);
        checkOutput("lockrst_fail",   fail_count, 0);
        applyBit(1'b0);
        checkOutput("lockrst_search", state, 1);
`else
        applyStimulus(0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            applyBit(1'b0);
            checkOutput("nolock_locked", locked_out, 0);
            checkOutput("nolock_fail",   fail_count, 0);
        end
        for (int i = 0; i < 5; i++) applyBit(seq_a[i]);
        checkOutput("nolock_unlocked", unlocked, 1);
`endif

        // Random traffic with occasional resets
        applyStimulus(0, 0, 1);
        for (int n = 0; n < 4000; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 199) == 0));
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
